wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back-side consumer of the MEM_WB pipeline register in the interrupt-capable pipelined CPU.
- Holds the 32 GPRs and the CP0 registers Status (12), Cause (13) and EPC (14).
- Performs the WB data selection, GPR and CP0 writes, and ID-stage reads with same-cycle write bypass.
- Sequences interrupt request, acknowledge and ERET.

Parameters:
- NREG, 32, number of GPRs (index 0 hardwired to zero).
- C0_STATUS, 12, CP0 index of Status (bit 0 = IE).
- C0_CAUSE, 13, CP0 index of Cause (bit 10 = IP2, external pending).
- C0_EPC, 14, CP0 index of EPC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWrite_i  in  1  write enable from MEM_WB.
- RegData_i  in  2  WB source select: 00 ALUResult, 01 MemData, 10/11 ALUResult.
- ALUResult_i  in  32  ALU result; also the mtc0 source data.
- MemData_i  in  32  load data.
- Rd_i  in  6  destination; bit5=1 selects CP0 index Rd_i[4:0].
- c0Data_i  in  32  CP0 value carried down the pipe for mfc0.
- mfc0_i  in  1  when 1, GPR write data = c0Data_i (overrides RegData_i).
- Rs_i  in  6  read address A (bit5 selects CP0).
- Rt_i  in  6  read address B (bit5 selects CP0).
- RsData_o  out  32  read data A, combinational.
- RtData_o  out  32  read data B, combinational.
- intr_i  in  1  external interrupt line, level.
- intr_ack_i  in  1  pipeline has taken the interrupt this cycle.
- epc_i  in  32  return PC captured on ack.
- eret_i  in  1  ERET retired this cycle.
- EPC_o  out  32  current EPC, for the ERET target.
- intr_req_o  out  1  registered interrupt request to the pipeline.

Behaviour:
- Reset (async, rst=1):
  - all GPRs = 0; Status = 0 (IE=0); Cause = 0; EPC = 0.
  - intr_req_o = 0; synchroniser flops = 0.
  - RsData_o and RtData_o then read 0 for every address.
- WB data: wdata = mfc0_i ? c0Data_i : (RegData_i==01 ? MemData_i : ALUResult_i).
- Writes:
  - At posedge with RegWrite_i=1: Rd_i[5]=0 writes GPR[Rd_i[4:0]]; Rd_i[5]=1 writes CP0[Rd_i[4:0]] (mtc0).
  - GPR 0 writes are dropped.
  - CP0 indices other than 12/13/14 are ignored and read 0.
  - Cause is read-only to mtc0 except bits [9:8] (software IP).
- Reads:
  - Combinational. GPR0 always reads 0.
  - Bypass: if RegWrite_i=1 and Rd_i equals the read address (all 6 bits, non-zero GPR or a valid CP0 index), return wdata, masked by the same write rules.
- Interrupt path:
  - intr_i goes through a 2-flop synchroniser; a rising edge of the synchronised signal sets Cause[10].
  - Cause[10] stays set while the line is held high; it clears only on ack.
  - intr_req_o <= Status[0] & Cause[10] & ~intr_ack_i (registered, 1-cycle latency).
  - intr_ack_i=1: EPC <= epc_i, Status[0] <= 0, Cause[10] <= 0. intr_req_o falls on the same edge.
  - eret_i=1: Status[0] <= 1.
- Simultaneous events:
  - ack and mtc0 Status in the same cycle: ack wins for IE; other Status bits take the mtc0 value.
  - ack and mtc0 EPC: epc_i wins.
  - ack and a new synchronised edge in the same cycle: Cause[10] stays 1 (set wins).
  - ack and eret in the same cycle: ack wins (IE=0).
  - intr_ack_i while intr_req_o=0: EPC, IE and Cause still update as above (no gating).
- Reset mid-operation: pending interrupts and in-flight writes are discarded immediately, asynchronously.

Test Plan:
- Reset, then read all 32 GPRs and CP0 12/13/14 -> every read 0; intr_req_o=0.
- RegWrite_i=1, Rd_i=5, RegData_i=01, MemData_i=32'hDEADBEEF, Rs_i=5 in the same cycle -> RsData_o=DEADBEEF (bypass) and after the edge. Repeat with Rd_i=0 -> GPR0 reads 0.
- mfc0_i=1, c0Data_i=32'h1234_5678, RegData_i=00, ALUResult_i=0, Rd_i=3 -> GPR3=12345678.
- mtc0 Status=1 (Rd_i=6'b101100, ALUResult_i=1); raise intr_i -> intr_req_o=1 exactly 4 cycles after the intr_i edge (2 sync + edge detect + request reg); Cause reads 32'h0000_0400.
- intr_ack_i=1, epc_i=32'h0040_0020 -> next cycle EPC_o=00400020, Status=0, Cause[10]=0, intr_req_o=0; then eret_i=1 -> Status=1.
- intr_ack_i, eret_i and an mtc0 Status=1 all in the same cycle -> Status[0]=0; assert rst mid-sequence -> all state 0 asynchronously.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs plus CP0 Status/Cause/EPC, combinational reads with same-cycle
// write bypass, and the interrupt request / acknowledge / ERET sequencing for the pipeline.
module wb_regfile #(
  parameter int NREG      = 32,
  parameter int C0_STATUS = 12,
  parameter int C0_CAUSE  = 13,
  parameter int C0_EPC    = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i,
  input  logic [1:0]  RegData_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [5:0]  Rd_i,
  input  logic [31:0] c0Data_i,
  input  logic        mfc0_i,
  input  logic [5:0]  Rs_i,
  input  logic [5:0]  Rt_i,
  output logic [31:0] RsData_o,
  output logic [31:0] RtData_o,
  input  logic        intr_i,
  input  logic        intr_ack_i,
  input  logic [31:0] epc_i,
  input  logic        eret_i,
  output logic [31:0] EPC_o,
  output logic        intr_req_o
);

  logic [31:0] gpr [NREG];
  logic [31:0] status, cause, epc;
  logic [31:0] status_nxt, cause_nxt, epc_nxt;
  logic [31:0] wdata;
  logic        sync1, sync2, sync3, intr_req;
  logic        rise, gpr_we, c0_we, wr_status, wr_cause, wr_epc;

  assign wdata     = mfc0_i ? c0Data_i : ((RegData_i == 2'b01) ? MemData_i : ALUResult_i);
  assign gpr_we    = RegWrite_i & ~Rd_i[5] & (Rd_i[4:0] != 5'd0);
  assign c0_we     = RegWrite_i & Rd_i[5];
  assign wr_status = c0_we & (Rd_i[4:0] == 5'(C0_STATUS));
  assign wr_cause  = c0_we & (Rd_i[4:0] == 5'(C0_CAUSE));
  assign wr_epc    = c0_we & (Rd_i[4:0] == 5'(C0_EPC));
  assign rise      = sync2 & ~sync3;

  // Priority order: mtc0, then eret, then ack (ack must win IE); a new edge beats ack on Cause[10].
  always_comb begin
    status_nxt = status;
    if (wr_status)  status_nxt = wdata;
    if (eret_i)     status_nxt[0] = 1'b1;
    if (intr_ack_i) status_nxt[0] = 1'b0;

    cause_nxt = cause;
    if (wr_cause)   cause_nxt[9:8] = wdata[9:8];
    if (intr_ack_i) cause_nxt[10] = 1'b0;
    if (rise)       cause_nxt[10] = 1'b1;

    epc_nxt = epc;
    if (wr_epc)     epc_nxt = wdata;
    if (intr_ack_i) epc_nxt = epc_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      cause    <= '0;
      epc      <= '0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      intr_req <= 1'b0;
    end else begin
      status   <= status_nxt;
      cause    <= cause_nxt;
      epc      <= epc_nxt;
      sync1    <= intr_i;
      sync2    <= sync1;
      sync3    <= sync2;
      intr_req <= status[0] & cause[10] & ~intr_ack_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[Rd_i[4:0]] <= wdata;
    end
  end

  // GPR0 is never written, so reading the array at index 0 already yields zero.
  function automatic logic [31:0] rd_port(input logic [5:0] a);
    logic [31:0] v;
    v = '0;
    if (a[5]) begin
      if (a[4:0] == 5'(C0_STATUS))     v = status;
      else if (a[4:0] == 5'(C0_CAUSE)) v = cause;
      else if (a[4:0] == 5'(C0_EPC))   v = epc;
    end else begin
      v = gpr[a[4:0]];
    end
    if (RegWrite_i && (Rd_i == a)) begin
      if (!a[5]) begin
        if (a[4:0] != 5'd0) v = wdata;
      end else if (a[4:0] == 5'(C0_STATUS)) begin
        v = wdata;
      end else if (a[4:0] == 5'(C0_CAUSE)) begin
        v = {cause[31:10], wdata[9:8], cause[7:0]};
      end else if (a[4:0] == 5'(C0_EPC)) begin
        v = wdata;
      end
    end
    return v;
  endfunction

  assign RsData_o   = rd_port(Rs_i);
  assign RtData_o   = rd_port(Rt_i);
  assign EPC_o      = epc;
  assign intr_req_o = intr_req;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, write rules, CP0 masking, interrupt timing and async reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_i;
  logic [1:0]  RegData_i;
  logic [31:0] ALUResult_i, MemData_i, c0Data_i, epc_i;
  logic [5:0]  Rd_i, Rs_i, Rt_i;
  logic        mfc0_i, intr_i, intr_ack_i, eret_i;
  logic [31:0] RsData_o, RtData_o, EPC_o;
  logic        intr_req_o;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] A_STATUS = 6'b101100;
  localparam logic [5:0] A_CAUSE  = 6'b101101;
  localparam logic [5:0] A_EPC    = 6'b101110;

  wb_regfile dut (
    .clk(clk), .rst(rst), .RegWrite_i(RegWrite_i), .RegData_i(RegData_i),
    .ALUResult_i(ALUResult_i), .MemData_i(MemData_i), .Rd_i(Rd_i), .c0Data_i(c0Data_i),
    .mfc0_i(mfc0_i), .Rs_i(Rs_i), .Rt_i(Rt_i), .RsData_o(RsData_o), .RtData_o(RtData_o),
    .intr_i(intr_i), .intr_ack_i(intr_ack_i), .epc_i(epc_i), .eret_i(eret_i),
    .EPC_o(EPC_o), .intr_req_o(intr_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_i = 0; RegData_i = 0; ALUResult_i = 0; MemData_i = 0; Rd_i = 0;
    c0Data_i = 0; mfc0_i = 0; intr_ack_i = 0; epc_i = 0; eret_i = 0;
  endtask

  task automatic read_rs(input string tag, input logic [5:0] a, input logic [31:0] exp);
    Rs_i = a;
    #1;
    chk(tag, RsData_o, exp);
  endtask

  initial begin
    rst = 1; intr_i = 0; Rs_i = 0; Rt_i = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    for (int i = 0; i < 32; i++) read_rs("rst_gpr", 6'(i), 32'h0);
    Rt_i = A_STATUS; #1 chk("rst_status", RtData_o, 32'h0);
    Rt_i = A_CAUSE;  #1 chk("rst_cause", RtData_o, 32'h0);
    Rt_i = A_EPC;    #1 chk("rst_epc", RtData_o, 32'h0);
    chk("rst_req", 32'(intr_req_o), 32'h0);

    // Load into GPR5 with bypass
    RegWrite_i = 1; Rd_i = 6'd5; RegData_i = 2'b01; MemData_i = 32'hDEADBEEF; ALUResult_i = 32'h11111111;
    read_rs("byp_gpr5", 6'd5, 32'hDEADBEEF);
    tick(); idle();
    read_rs("gpr5", 6'd5, 32'hDEADBEEF);
    Rt_i = 6'd5; #1 chk("gpr5_rt", RtData_o, 32'hDEADBEEF);

    // GPR0 write dropped
    RegWrite_i = 1; Rd_i = 6'd0; RegData_i = 2'b01; MemData_i = 32'hDEADBEEF;
    read_rs("byp_gpr0", 6'd0, 32'h0);
    tick(); idle();
    read_rs("gpr0", 6'd0, 32'h0);

    // mfc0 data overrides select
    RegWrite_i = 1; mfc0_i = 1; c0Data_i = 32'h12345678; RegData_i = 2'b00; ALUResult_i = 0; Rd_i = 6'd3;
    tick(); idle();
    read_rs("mfc0_gpr3", 6'd3, 32'h12345678);

    // RegData 10 selects ALU result
    RegWrite_i = 1; RegData_i = 2'b10; ALUResult_i = 32'hA5A5A5A5; MemData_i = 32'hFFFFFFFF; Rd_i = 6'd7;
    tick(); idle();
    read_rs("sel10_gpr7", 6'd7, 32'hA5A5A5A5);

    // Cause only takes bits [9:8] from mtc0
    RegWrite_i = 1; Rd_i = A_CAUSE; ALUResult_i = 32'hFFFFFFFF;
    read_rs("byp_cause", A_CAUSE, 32'h00000300);
    tick(); idle();
    read_rs("cause_sw", A_CAUSE, 32'h00000300);
    RegWrite_i = 1; Rd_i = A_CAUSE; ALUResult_i = 32'h0;
    tick(); idle();
    read_rs("cause_clr", A_CAUSE, 32'h0);

    // Unimplemented CP0 index
    RegWrite_i = 1; Rd_i = 6'b100101; ALUResult_i = 32'hFFFFFFFF;
    read_rs("byp_c0_5", 6'b100101, 32'h0);
    tick(); idle();
    read_rs("c0_5", 6'b100101, 32'h0);

    // Enable interrupts, then measure request latency
    RegWrite_i = 1; Rd_i = A_STATUS; ALUResult_i = 32'h1;
    tick(); idle();
    read_rs("status_ie", A_STATUS, 32'h1);
    intr_i = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("req_lat%0d", k), 32'(intr_req_o), (k == 4) ? 32'h1 : 32'h0);
    end
    read_rs("cause_ip2", A_CAUSE, 32'h00000400);

    // Acknowledge
    intr_ack_i = 1; epc_i = 32'h00400020; intr_i = 0;
    tick(); idle();
    chk("ack_epc_o", EPC_o, 32'h00400020);
    chk("ack_req", 32'(intr_req_o), 32'h0);
    read_rs("ack_status", A_STATUS, 32'h0);
    read_rs("ack_cause", A_CAUSE, 32'h0);
    read_rs("ack_epc_rd", A_EPC, 32'h00400020);
    tick();
    chk("ack_req2", 32'(intr_req_o), 32'h0);

    // ERET re-enables
    eret_i = 1;
    tick(); idle();
    read_rs("eret_status", A_STATUS, 32'h1);

    // ack + eret + mtc0 Status together: ack wins IE, upper bits from mtc0
    RegWrite_i = 1; Rd_i = A_STATUS; ALUResult_i = 32'h0000FF01;
    intr_ack_i = 1; eret_i = 1; epc_i = 32'h00400080;
    tick(); idle();
    read_rs("sim_status", A_STATUS, 32'h0000FF00);
    chk("sim_epc", EPC_o, 32'h00400080);

    // ack + mtc0 EPC: epc_i wins
    RegWrite_i = 1; Rd_i = A_EPC; ALUResult_i = 32'hDEAD0000; intr_ack_i = 1; epc_i = 32'h00400100;
    tick(); idle();
    chk("ack_vs_mtc0_epc", EPC_o, 32'h00400100);

    // Build up pending state, then reset asynchronously mid-cycle
    eret_i = 1;
    tick(); idle();
    intr_i = 1;
    repeat (4) tick();
    chk("pre_rst_req", 32'(intr_req_o), 32'h1);
    RegWrite_i = 1; Rd_i = 6'd9; ALUResult_i = 32'h55; intr_i = 0; Rt_i = 6'd3;
    #2 rst = 1;
    #1;
    chk("arst_req", 32'(intr_req_o), 32'h0);
    chk("arst_epc", EPC_o, 32'h0);
    chk("arst_gpr3", RtData_o, 32'h0);
    read_rs("arst_gpr5", 6'd5, 32'h0);
    read_rs("arst_status", A_STATUS, 32'h0);
    read_rs("arst_cause", A_CAUSE, 32'h0);
    tick(); idle();
    #1 rst = 0;
    read_rs("arst_gpr9", 6'd9, 32'h0);
    tick();
    chk("post_rst_req", 32'(intr_req_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
